// File: rtl/vector_exec_unit.sv
// Multi-cycle lane-wise vector execute stage: latches operands on start, processes
// P lanes per cycle over V/P chunks, then strobes valid_o with a registered zero flag.
module vector_exec_unit #(
   parameter int N = 32,
   parameter int V = 20,
   parameter int L = 8,
   parameter int P = 4
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           start_i,
   input  logic [1:0]     OpType_i,
   input  logic [1:0]     ALUControl_i,
   input  logic           ALUSource_i,
   input  logic [N-1:0]   RD2_S_i,
   input  logic [N-1:0]   Extend_i,
   input  logic [V*L-1:0] RD1_V_i,
   input  logic [V*L-1:0] RD2_V_i,
   output logic           stall_o,
   output logic           busy_o,
   output logic           valid_o,
   output logic [V*L-1:0] result_o,
   output logic           zero_o
);

   localparam int CHUNKS = V / P;
   localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   typedef enum logic [1:0] {OP_SCALAR = 2'b00, OP_VV = 2'b01, OP_VS = 2'b10, OP_RSVD = 2'b11} optype_t;
   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11} alu_t;

   if (V % P != 0) begin : g_bad_lane_split
      $error("vector_exec_unit: V must be a multiple of P");
   end

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [V*L-1:0]   a_q, b_q;
   alu_t             alu_q;
   logic [V*L-1:0]   result_q, result_next;
   logic             zero_q;
   logic             vec_op;
   logic             last_chunk;
   logic [L-1:0]     vs_scalar;
   logic             unused_hi_bits;

   assign vec_op     = start_i && (OpType_i == OP_VV || OpType_i == OP_VS);
   assign last_chunk = (idx_q == LAST_IDX);
   assign vs_scalar  = ALUSource_i ? Extend_i[L-1:0] : RD2_S_i[L-1:0];

   // Only the low L bits of a scalar operand reach the lanes.
   assign unused_hi_bits = ^{RD2_S_i[N-1:L], Extend_i[N-1:L]};

   function automatic logic [L-1:0] lane_op(input alu_t op, input logic [L-1:0] a, input logic [L-1:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         default: return '0;
      endcase
   endfunction

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (vec_op) state_d = S_BUSY;
         S_BUSY:  if (last_chunk) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy_o  = (state_q == S_BUSY);
      valid_o = (state_q == S_DONE);
      stall_o = ((state_q == S_IDLE) && vec_op) || (state_q == S_BUSY);
   end

   // Current chunk merged into the held result; lanes outside the chunk keep their value.
   always_comb begin
      result_next = result_q;
      for (int j = 0; j < P; j++) begin
         result_next[(int'(idx_q) * P + j) * L +: L] =
            lane_op(alu_q, a_q[(int'(idx_q) * P + j) * L +: L], b_q[(int'(idx_q) * P + j) * L +: L]);
      end
   end

   // NOTE: operand latches carry no reset; they are always written on start before BUSY reads them.
   always_ff @(posedge CLK) begin
      if (state_q == S_IDLE && vec_op) begin
         a_q   <= RD1_V_i;
         b_q   <= (OpType_i == OP_VV) ? RD2_V_i : {V{vs_scalar}};
         alu_q <= alu_t'(ALUControl_i);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         idx_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (vec_op) idx_q <= '0;
            S_BUSY: begin
               result_q <= result_next;
               if (last_chunk) begin
                  idx_q  <= '0;
                  zero_q <= (result_next == '0);
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign result_o = result_q;
   assign zero_o   = zero_q;

endmodule

// File: doc/vector_exec_unit.md
# vector_exec_unit

Multi-cycle vector execute stage that consumes the ID/EX pipeline register outputs and performs lane-wise vector arithmetic on V lanes of L bits, P lanes per cycle. It latches operands on start, iterates over V/P chunks, and holds the upstream pipeline via a stall output while busy. It presents a completed result vector with a one-cycle valid strobe and a zero flag to the EX/MEM stage.

## Interface
- N, 32, scalar datapath width
- V, 20, vector lanes
- L, 8, bits per lane
- P, 4, lanes processed per cycle; V must be a multiple of P (elaboration error otherwise)

- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- start_i  in  1  ID/EX holds a valid instruction this cycle
- OpType_i  in  2  00 scalar, 01 vector-vector, 10 vector-scalar, 11 reserved
- ALUControl_i  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- ALUSource_i  in  1  vector-scalar operand B source: 0 RD2_S_i, 1 Extend_i
- RD2_S_i  in  N  scalar register operand
- Extend_i  in  N  extended immediate
- RD1_V_i  in  V×L  vector operand A, lane 0 in bits [L-1:0]
- RD2_V_i  in  V×L  vector operand B
- stall_o  out  1  hold upstream stages (drives ID/EX enable_i inverted)
- busy_o  out  1  state is BUSY
- valid_o  out  1  one-cycle strobe: result_o complete
- result_o  out  V×L  result vector, lane 0 in bits [L-1:0]
- zero_o  out  1  all lanes of result_o zero; meaningful only with valid_o

## Operation
- States: IDLE, BUSY, DONE. Chunk counter idx, width clog2(V/P).
- Vector op = start_i & (OpType_i == 01 or 10). Scalar/reserved ops: no state change, stall_o 0.
- IDLE & vector op: latch A = RD1_V_i, B-vector (RD2_V_i for 01; for 10, every lane = low L bits of RD2_S_i if ALUSource_i=0 else Extend_i), ALUControl; idx←0; →BUSY.
- BUSY: lanes idx·P … idx·P+P-1 computed from latched operands and written into result register; other lanes unchanged. idx==V/P-1 → DONE, else idx+1.
- DONE: valid_o=1, zero_o valid; →IDLE unconditionally. start_i in DONE ignored (it is the same instruction still held in ID/EX).
- Lane arithmetic: ADD/SUB modulo 2^L, no carry between lanes, no saturation; AND/OR bitwise.
- stall_o = (IDLE & vector op) | BUSY. Low in DONE so ID/EX advances at the end of DONE.
- result_o holds its value until overwritten chunk by chunk by the next operation; partial values visible during BUSY, qualified only by valid_o.
- zero_o registered, computed from final result, updated on entry to DONE, held after.

## Timing
- Reset values: state IDLE, idx 0, result_o 0, zero_o 0, valid_o 0, busy_o 0; stall_o 0 (no start during reset considered).
- Cycle 0: start sampled in IDLE, stall_o 1 (combinational). Cycles 1…V/P: BUSY (5 with defaults), stall_o 1. Cycle V/P+1: DONE, valid_o 1, stall_o 0. Total latency from start to valid: V/P+1 cycles (6 default).
- Back-to-back vector ops: next start accepted earliest in IDLE cycle after DONE; one idle bubble minimum.
- Operand inputs may change after cycle 0 without effect.
- RST mid-BUSY/DONE: next cycle IDLE, result_o 0, valid_o 0, stall_o 0; in-flight op discarded.
- RST with start_i high: reset wins.

## Test plan
- Reset then idle: all outputs 0; start_i=1 with OpType_i=00 → stall_o stays 0, no valid_o.
- VV ADD: A lanes = 0xF0, B lanes = 0x20, start at cycle 0 → stall_o 1 cycles 0–5, valid_o only at cycle 6, every lane 0x10 (wrap), zero_o 0.
- VS SUB from immediate: A lane i = i, ALUSource_i=1, Extend_i=0x0000_0105 → each lane = i−0x05 mod 256 (lane 0 = 0xFB), lane 5 = 0x00.
- VV AND producing all zeros: A=0xAA, B=0x55 → valid_o with zero_o 1; then OR same operands → all 0xFF, zero_o 0.
- Operand hold: change RD1_V_i every cycle after start → result reflects cycle-0 operands; start_i held high through DONE → exactly one valid_o, next op accepted only after IDLE.
- RST asserted in BUSY cycle 3 → next cycle state IDLE, result_o 0, valid_o never pulses, stall_o 0.
